// File: rtl/dram_net_bridge.sv
// Bridges a DRAM command/data interface onto a flit network: writes and read requests
// leave as a header flit (+ write data), read bursts return on the ingress port.
module dram_net_bridge #(
    parameter int NetworkWidth   = 64,
    parameter int DDRAWidth      = 28,
    parameter int DDRCWidth      = 3,
    parameter int BurstFlits     = 8,
    parameter int MaxOutstanding = 4,
    parameter int CmdWrite       = 0,
    parameter int CmdRead        = 1
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic [DDRAWidth-1:0]                  DRAMAddress,
    input  logic [DDRCWidth-1:0]                  DRAMCommand,
    input  logic                                  DRAMCommandValid,
    output logic                                  DRAMCommandReady,
    input  logic [NetworkWidth-1:0]               DRAMWriteData,
    input  logic                                  DRAMWriteDataValid,
    output logic                                  DRAMWriteDataReady,
    output logic [NetworkWidth-1:0]               DRAMReadData,
    output logic                                  DRAMReadDataValid,
    output logic [NetworkWidth-1:0]               NetOut,
    output logic                                  NetOutValid,
    input  logic                                  NetOutReady,
    input  logic [NetworkWidth-1:0]               NetIn,
    input  logic                                  NetInValid,
    output logic                                  NetInReady,
    output logic [$clog2(MaxOutstanding+1)-1:0]   ReadsOutstanding,
    output logic                                  Error
);

    localparam int BW = $clog2(BurstFlits);
    localparam int OW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {IDLE, HDR, WDATA} state_e;

    state_e                  state_q;
    logic [NetworkWidth-1:0] header_q, header_d;
    logic                    is_read_q;
    logic [BW-1:0]           beat_q;
    logic [BW-1:0]           in_cnt_q;
    logic [OW-1:0]           rd_out_q;
    logic                    err_q;
    logic                    rvalid_q;
    logic [NetworkWidth-1:0] rdata_q;

    logic cmd_is_read, cmd_is_write, cmd_hs, hdr_hs, wr_hs;
    logic in_drop, in_acc, burst_done, rd_inc;

    assign cmd_is_read  = (DRAMCommand == DDRCWidth'(CmdRead));
    assign cmd_is_write = (DRAMCommand == DDRCWidth'(CmdWrite));
    assign cmd_hs       = DRAMCommandReady && DRAMCommandValid;
    assign hdr_hs       = (state_q == HDR) && NetOutReady;
    assign wr_hs        = (state_q == WDATA) && DRAMWriteDataValid && NetOutReady;
    assign rd_inc       = hdr_hs && is_read_q;

    // A flit with nothing requested and no burst in progress is unsolicited.
    assign in_drop    = NetInValid && (rd_out_q == '0) && (in_cnt_q == '0);
    assign in_acc     = NetInValid && !in_drop;
    assign burst_done = in_acc && (in_cnt_q == BW'(BurstFlits - 1));

    always_comb begin
        header_d = '0;
        header_d[NetworkWidth-1 -: 8] = 8'(DRAMCommand);
        header_d[DDRAWidth-1:0]       = DRAMAddress;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            header_q  <= '0;
            is_read_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_hs && (cmd_is_read || cmd_is_write)) begin
                        header_q  <= header_d;
                        is_read_q <= cmd_is_read;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (NetOutReady) begin
                        state_q <= is_read_q ? IDLE : WDATA;
                        beat_q  <= '0;
                    end
                end
                WDATA: begin
                    if (wr_hs) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == BW'(BurstFlits - 1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            rvalid_q <= in_acc;
            if (in_acc) begin
                rdata_q  <= NetIn;
                in_cnt_q <= in_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_out_q <= '0;
        end else begin
            case ({rd_inc, burst_done})
                2'b10:   rd_out_q <= rd_out_q + 1'b1;
                2'b01:   rd_out_q <= rd_out_q - 1'b1;
                default: rd_out_q <= rd_out_q;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (cmd_hs && !cmd_is_read && !cmd_is_write) | in_drop;
        end
    end

    assign DRAMCommandReady   = (state_q == IDLE) &&
                                !(cmd_is_read && (rd_out_q == OW'(MaxOutstanding)));
    assign NetOut             = (state_q == WDATA) ? DRAMWriteData : header_q;
    assign NetOutValid        = (state_q == HDR) || ((state_q == WDATA) && DRAMWriteDataValid);
    assign DRAMWriteDataReady = (state_q == WDATA) && NetOutReady;
    assign NetInReady         = 1'b1;
    assign DRAMReadData       = rdata_q;
    assign DRAMReadDataValid  = rvalid_q;
    assign ReadsOutstanding   = rd_out_q;
    assign Error              = err_q;

endmodule

// File: tb/tb_dram_net_bridge.sv
// Checks dram_net_bridge cycle by cycle against a transaction-level model of the bridge,
// using directed scenarios followed by a randomized traffic phase.
module tb_dram_net_bridge;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [27:0] DRAMAddress;
    logic [2:0]  DRAMCommand;
    logic        DRAMCommandValid;
    logic        DRAMCommandReady;
    logic [63:0] DRAMWriteData;
    logic        DRAMWriteDataValid;
    logic        DRAMWriteDataReady;
    logic [63:0] DRAMReadData;
    logic        DRAMReadDataValid;
    logic [63:0] NetOut;
    logic        NetOutValid;
    logic        NetOutReady;
    logic [63:0] NetIn;
    logic        NetInValid;
    logic        NetInReady;
    logic [2:0]  ReadsOutstanding;
    logic        Error;

    dram_net_bridge #(
        .NetworkWidth(64), .DDRAWidth(28), .DDRCWidth(3), .BurstFlits(8),
        .MaxOutstanding(4), .CmdWrite(0), .CmdRead(1)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .DRAMAddress(DRAMAddress), .DRAMCommand(DRAMCommand),
        .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady),
        .DRAMWriteData(DRAMWriteData), .DRAMWriteDataValid(DRAMWriteDataValid),
        .DRAMWriteDataReady(DRAMWriteDataReady),
        .DRAMReadData(DRAMReadData), .DRAMReadDataValid(DRAMReadDataValid),
        .NetOut(NetOut), .NetOutValid(NetOutValid), .NetOutReady(NetOutReady),
        .NetIn(NetIn), .NetInValid(NetInValid), .NetInReady(NetInReady),
        .ReadsOutstanding(ReadsOutstanding), .Error(Error)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: a pending header, write beats still owed, reads in flight.
    bit          hdr_pending;
    bit          hdr_read;
    logic [63:0] hdr_val;
    int          beats_left;
    int          outstanding;
    int          partial;
    bit          m_err;
    bit          exp_rvalid;
    logic [63:0] exp_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hdr_pending = 0; hdr_read = 0; hdr_val = '0; beats_left = 0;
        outstanding = 0; partial = 0; m_err = 0; exp_rvalid = 0; exp_rdata = '0;
    endtask

    function automatic bit model_cmd_ready();
        return !hdr_pending && beats_left == 0 && !(DRAMCommand == 3'd1 && outstanding == 4);
    endfunction

    task automatic check_cycle();
        bit ov;
        ov = hdr_pending || (beats_left > 0 && DRAMWriteDataValid);
        chk("cmd_ready", DRAMCommandReady, model_cmd_ready());
        chk("net_out_valid", NetOutValid, ov);
        if (ov) chk("net_out", NetOut, hdr_pending ? hdr_val : DRAMWriteData);
        chk("wd_ready", DRAMWriteDataReady, beats_left > 0 && NetOutReady);
        chk("reads_outstanding", ReadsOutstanding, outstanding);
        chk("error", Error, m_err);
        chk("net_in_ready", NetInReady, 1'b1);
        chk("rd_valid", DRAMReadDataValid, exp_rvalid);
        if (exp_rvalid) chk("rd_data", DRAMReadData, exp_rdata);
    endtask

    task automatic model_update();
        bit acc;
        int inc, dec;
        acc = model_cmd_ready() && DRAMCommandValid;
        inc = 0; dec = 0;
        if (hdr_pending && NetOutReady) begin
            hdr_pending = 0;
            if (hdr_read) inc = 1;
            else beats_left = 8;
        end else if (beats_left > 0 && DRAMWriteDataValid && NetOutReady) begin
            beats_left--;
        end
        if (acc) begin
            if (DRAMCommand <= 3'd1) begin
                hdr_pending = 1;
                hdr_read    = (DRAMCommand == 3'd1);
                hdr_val     = (64'(DRAMCommand) << 56) | 64'(DRAMAddress);
            end else begin
                m_err = 1;
            end
        end
        exp_rvalid = 0;
        if (NetInValid) begin
            if (outstanding == 0 && partial == 0) begin
                m_err = 1;
            end else begin
                exp_rvalid = 1;
                exp_rdata  = NetIn;
                partial++;
                if (partial == 8) begin
                    partial = 0;
                    dec = 1;
                end
            end
        end
        outstanding = outstanding + inc - dec;
    endtask

    // Inputs are changed just after a rising edge; checks happen on the falling edge.
    task automatic step();
        @(negedge Clock);
        check_cycle();
        if (!Reset) model_update();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        DRAMCommandValid = 0; DRAMCommand = '0; DRAMAddress = '0;
        DRAMWriteDataValid = 0; DRAMWriteData = '0;
        NetOutReady = 1; NetInValid = 0; NetIn = '0;
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr);
        DRAMCommand = cmd; DRAMAddress = addr; DRAMCommandValid = 1;
        step();
        DRAMCommandValid = 0;
    endtask

    task automatic return_burst(input logic [63:0] base);
        for (int i = 0; i < 8; i++) begin
            NetInValid = 1; NetIn = base + 64'(i);
            step();
        end
        NetInValid = 0;
    endtask

    task automatic pulse_reset();
        Reset = 1;
        #1;
        chk("rst_net_out_valid", NetOutValid, 1'b0);
        chk("rst_wd_ready", DRAMWriteDataReady, 1'b0);
        chk("rst_rd_valid", DRAMReadDataValid, 1'b0);
        chk("rst_rd_data", DRAMReadData, 64'd0);
        chk("rst_outstanding", ReadsOutstanding, 3'd0);
        chk("rst_error", Error, 1'b0);
        model_reset();
        step();
        Reset = 0;
    endtask

    initial begin
        Reset = 1;
        idle_inputs();
        model_reset();
        #1;
        step();
        step();
        Reset = 0;
        chk("cmd_ready_after_reset", DRAMCommandReady, 1'b1);

        // Write at 0x123, full burst with the network always ready.
        send_cmd(3'd0, 28'h0000123);
        chk("wr_hdr_latency", NetOutValid, 1'b1);
        chk("wr_hdr_value", NetOut, 64'h0000_0000_0000_0123);
        step();
        for (int i = 0; i < 8; i++) begin
            DRAMWriteDataValid = 1; DRAMWriteData = 64'hD0D0_0000_0000_0000 + 64'(i);
            step();
        end
        DRAMWriteDataValid = 0;
        chk("wr_back_idle", DRAMCommandReady, 1'b1);

        // Read at 0xABCDEF and its returning burst.
        send_cmd(3'd1, 28'h0ABCDEF);
        chk("rd_hdr_value", NetOut, 64'h0100_0000_00AB_CDEF);
        step();
        chk("rd_outstanding_one", ReadsOutstanding, 3'd1);
        return_burst(64'd0);
        chk("rd_outstanding_zero", ReadsOutstanding, 3'd0);
        chk("rd_last_data", DRAMReadData, 64'd7);
        step();

        // Five reads without returns: the fifth is held off until a burst comes back.
        for (int i = 0; i < 4; i++) begin
            send_cmd(3'd1, 28'(i * 16));
            step();
        end
        chk("max_outstanding", ReadsOutstanding, 3'd4);
        DRAMCommand = 3'd1; DRAMAddress = 28'h50; DRAMCommandValid = 1;
        #1;
        chk("fifth_read_blocked", DRAMCommandReady, 1'b0);
        return_burst(64'h100);
        step();
        DRAMCommandValid = 0;
        step();
        chk("fifth_read_sent", ReadsOutstanding, 3'd4);
        for (int b = 0; b < 4; b++) return_burst(64'h200 + 64'(b * 8));
        step();

        // Back-pressure during the header and at write beat 3.
        send_cmd(3'd0, 28'h0000456);
        NetOutReady = 0;
        for (int i = 0; i < 10; i++) step();
        NetOutReady = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            DRAMWriteDataValid = 1; DRAMWriteData = 64'hBEEF_0000_0000_0000 + 64'(i);
            if (i == 3) begin
                NetOutReady = 0;
                for (int k = 0; k < 10; k++) step();
                NetOutReady = 1;
            end
            step();
        end
        DRAMWriteDataValid = 0;
        chk("bp_back_idle", DRAMCommandReady, 1'b1);

        // Unsolicited flit and an unknown command both raise the sticky error.
        NetInValid = 1; NetIn = 64'hBAD;
        step();
        NetInValid = 0;
        send_cmd(3'd3, 28'h77);
        step();
        chk("err_sticky", Error, 1'b1);
        chk("err_no_rd_valid", DRAMReadDataValid, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("err_still_set", Error, 1'b1);

        // Reset at write beat 4, then a clean write.
        send_cmd(3'd0, 28'h0000999);
        step();
        for (int i = 0; i < 4; i++) begin
            DRAMWriteDataValid = 1; DRAMWriteData = 64'(i);
            step();
        end
        pulse_reset();
        chk("post_reset_ready", DRAMCommandReady, 1'b1);
        DRAMWriteDataValid = 0;
        send_cmd(3'd0, 28'h0000AAA);
        step();
        for (int i = 0; i < 8; i++) begin
            DRAMWriteDataValid = 1; DRAMWriteData = 64'hCAFE_0000_0000_0000 + 64'(i);
            step();
        end
        DRAMWriteDataValid = 0;
        step();

        // Randomized mixed traffic.
        for (int c = 0; c < 1500; c++) begin
            int r;
            DRAMCommandValid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            DRAMCommand = (r < 10) ? 3'd0 : (r < 19) ? 3'd1 : 3'($urandom_range(2, 7));
            DRAMAddress = 28'($urandom);
            DRAMWriteDataValid = ($urandom_range(0, 3) != 0);
            DRAMWriteData = {32'($urandom), 32'($urandom)};
            NetOutReady = ($urandom_range(0, 3) != 0);
            if (outstanding > 0 || partial > 0) NetInValid = ($urandom_range(0, 1) == 1);
            else NetInValid = ($urandom_range(0, 49) == 0);
            NetIn = {32'($urandom), 32'($urandom)};
            step();
        end

        idle_inputs();
        pulse_reset();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_net_bridge.md
DRAM_NET_BRIDGE -- requirements
Module: dram_net_bridge

Interface
REQ-001 SHALL have parameter NetworkWidth, default 64, network flit width in bits.
REQ-002 SHALL have parameter DDRAWidth, default 28, DRAM address width.
REQ-003 SHALL have parameter DDRCWidth, default 3, DRAM command width.
REQ-004 SHALL have parameter BurstFlits, default 8, flits per DRAM burst; power of two, at least 2.
REQ-005 SHALL have parameter MaxOutstanding, default 4, maximum number of read bursts in flight.
REQ-006 SHALL have parameters CmdWrite, default 0, and CmdRead, default 1, giving the DRAM command encodings.
REQ-007 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port Reset, input, 1 bit: reset is asynchronous and active-high.
REQ-009 SHALL have upstream command ports: DRAMAddress in [DDRAWidth], DRAMCommand in [DDRCWidth], DRAMCommandValid in 1, DRAMCommandReady out 1.
REQ-010 SHALL have upstream write ports: DRAMWriteData in [NetworkWidth], DRAMWriteDataValid in 1, DRAMWriteDataReady out 1.
REQ-011 SHALL have upstream read ports: DRAMReadData out [NetworkWidth] and DRAMReadDataValid out 1; this interface has no backpressure.
REQ-012 SHALL have network egress ports: NetOut out [NetworkWidth], NetOutValid out 1, NetOutReady in 1.
REQ-013 SHALL have network ingress ports: NetIn in [NetworkWidth], NetInValid in 1, NetInReady out 1.
REQ-014 SHALL have debug outputs: ReadsOutstanding out [clog2(MaxOutstanding+1)], and Error out 1 (sticky).

Function
REQ-015 SHALL implement the FSM states IDLE, HDR and WDATA; Reset enters IDLE.
REQ-016 SHALL assert DRAMCommandReady = (state==IDLE) && !(DRAMCommand==CmdRead && ReadsOutstanding==MaxOutstanding).
REQ-017 SHALL register the header on a command handshake in IDLE: bits [NetworkWidth-1:NetworkWidth-8] = DRAMCommand zero-extended to 8 bits, low DDRAWidth bits = DRAMAddress, all other bits 0.
REQ-018 On that handshake, SHALL go to HDR if the command is CmdRead or CmdWrite.
REQ-019 On that handshake, any other command SHALL be consumed, SHALL produce no network traffic, SHALL set Error, and the FSM SHALL stay in IDLE.
REQ-020 In HDR, SHALL drive NetOutValid=1 and NetOut=header; both SHALL hold stable until NetOutReady.
REQ-021 On the HDR handshake, a read SHALL increment ReadsOutstanding and return to IDLE; a write SHALL go to WDATA with the beat counter at 0.
REQ-022 SHALL give a header latency of exactly 1 cycle: command accepted in cycle T means NetOutValid is first high in cycle T+1.
REQ-023 In WDATA, SHALL drive combinationally NetOut=DRAMWriteData, NetOutValid=DRAMWriteDataValid and DRAMWriteDataReady=NetOutReady.
REQ-024 In WDATA, SHALL count each handshake; on the BurstFlits-th handshake it SHALL return to IDLE.
REQ-025 Outside WDATA, DRAMWriteDataReady SHALL be 0, and NetOutValid SHALL be 0 except in HDR.
REQ-026 SHALL tie NetInReady to 1.
REQ-027 For each NetIn flit, SHALL drive DRAMReadData=NetIn and DRAMReadDataValid=1 registered: flit in cycle T appears in cycle T+1.
REQ-028 SHALL count ingress flits modulo BurstFlits; the BurstFlits-th flit of a burst SHALL decrement ReadsOutstanding.
REQ-029 If ReadsOutstanding==0 and no burst is partially received, an ingress flit SHALL be dropped (DRAMReadDataValid stays 0) and Error set.
REQ-030 Increment and decrement of ReadsOutstanding in the same cycle SHALL leave it unchanged.
REQ-031 ReadsOutstanding SHALL never exceed MaxOutstanding and never go below 0.
REQ-032 The ingress path SHALL operate independently of the FSM; egress and ingress traffic in the same cycle SHALL both proceed.
REQ-033 Error SHALL clear only on Reset.

Reset
REQ-034 Asserting Reset at any time, including mid-burst, SHALL immediately force: FSM=IDLE, beat counters=0, ReadsOutstanding=0, Error=0, NetOutValid=0, DRAMReadDataValid=0, DRAMWriteDataReady=0, registered DRAMReadData=0.
REQ-035 After Reset, any partially sent burst SHALL be abandoned and not resumed.
REQ-036 DRAMCommandReady SHALL be 1 in the first cycle after Reset deasserts.

Verification
REQ-037 Write at addr 0x0000123 with NetOutReady=1 -> header 0x0000_0000_0000_0123 in cycle T+1, then 8 data flits passed through, then back to IDLE (DRAMCommandReady=1).
REQ-038 Read at addr 0x0ABCDEF, then 8 NetIn flits 0..7 -> header 0x0100_0000_00AB_CDEF; ReadsOutstanding goes 1 then 0; DRAMReadData 0..7 each one cycle after its input.
REQ-039 Issue 5 reads with no returns -> 4 headers sent, DRAMCommandReady=0 for the 5th read; after one 8-flit return, the 5th read is accepted.
REQ-040 Hold NetOutReady=0 for 10 cycles during HDR and in mid-WDATA at beat 3 -> NetOut/NetOutValid stable, DRAMWriteDataReady=0; on release, the remaining 5 beats complete with no loss.
REQ-041 Send a NetIn flit with 0 outstanding, then issue command 3 -> both dropped, Error=1, no DRAMReadDataValid; Error stays 1 until Reset.
REQ-042 Assert Reset at write beat 4 -> all outputs at reset values the same cycle; the next write completes normally.
